// File: rtl/tri_count_checker.sv
// tri_count_checker
//   Receive-side monitor for an up/down bounce counter (0 -> MAX -> 0, each
//   endpoint held for one sample). It locks onto the observed sequence,
//   predicts the next value, and flags peaks, troughs and sequence errors.
//   It also keeps a saturating error tally.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   in_count carries a sample this cycle
//   in_count   observed counter value (WIDTH bits)
//   err_clr    clears err_count (a coincident mismatch leaves it at 1)
//   locked     checker is tracking the sequence
//   dir        direction of the next expected step (1 = up, 0 = down)
//   peak       one-cycle pulse: accepted sample == MAX
//   trough     one-cycle pulse: accepted sample == 0
//   err        one-cycle pulse: sample mismatched the prediction while locked
//   err_count  saturating 8-bit error tally
module tri_count_checker #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_count,
    input  logic             err_clr,
    output logic             locked,
    output logic             dir,
    output logic             peak,
    output logic             trough,
    output logic             err,
    output logic [7:0]       err_count
);

    localparam logic [WIDTH-1:0] MAX  = '1;
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    typedef enum logic [1:0] {EMPTY, HUNT, LOCKED} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             dir_q, dir_d;
    logic             peak_q, peak_d;
    logic             trough_q, trough_d;
    logic             err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;

    logic up_step, dn_step, accept, step_up, mismatch;

    // Endpoint guards are evaluated on prev before the +/-1, so the WIDTH-bit
    // wrap of the adders can never produce a false step (7->0 or 0->7).
    assign up_step = (prev_q != MAX)  && (in_count == prev_q + ONE);
    assign dn_step = (prev_q != ZERO) && (in_count == prev_q - ONE);

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        dir_d    = dir_q;
        peak_d   = 1'b0;
        trough_d = 1'b0;
        accept   = 1'b0;
        step_up  = dir_q;
        mismatch = 1'b0;

        if (in_valid) begin
            // Every valid sample becomes the new reference value.
            prev_d = in_count;
            case (state_q)
                EMPTY: state_d = HUNT;
                HUNT: begin
                    if (up_step) begin
                        accept  = 1'b1;
                        step_up = 1'b1;
                    end else if (dn_step) begin
                        accept  = 1'b1;
                        step_up = 1'b0;
                    end
                end
                LOCKED: begin
                    if (dir_q ? up_step : dn_step) begin
                        accept = 1'b1;
                    end else begin
                        // Direction is kept so a re-lock starts from the last belief.
                        mismatch = 1'b1;
                        state_d  = HUNT;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        if (accept) begin
            state_d  = LOCKED;
            peak_d   = (in_count == MAX);
            trough_d = (in_count == ZERO);
            // Endpoints force the turn-around; otherwise follow the step just seen.
            if (in_count == MAX)       dir_d = 1'b0;
            else if (in_count == ZERO) dir_d = 1'b1;
            else                       dir_d = step_up;
        end

        err_d = mismatch;

        cnt_d = cnt_q;
        if (err_clr)                          cnt_d = {7'd0, mismatch};
        else if (mismatch && cnt_q != 8'hFF)  cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            prev_q   <= '0;
            dir_q    <= 1'b1;
            peak_q   <= 1'b0;
            trough_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            dir_q    <= dir_d;
            peak_q   <= peak_d;
            trough_q <= trough_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign dir       = dir_q;
    assign peak      = peak_q;
    assign trough    = trough_q;
    assign err       = err_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_tri_count_checker.sv
module tb_tri_count_checker;

    localparam int WIDTH = 3;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_count = '0;
    logic             err_clr = 1'b0;
    logic             locked, dir, peak, trough, err;
    logic [7:0]       err_count;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    tri_count_checker #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_count(in_count),
        .err_clr(err_clr), .locked(locked), .dir(dir), .peak(peak),
        .trough(trough), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // mode: 0 = nothing seen yet, 1 = searching for a +/-1 step, 2 = tracking
    int m_mode = 0, m_prev = 0, m_dir = 1, m_cnt = 0;
    int m_peak = 0, m_trough = 0, m_err = 0;

    task automatic m_accept(input int s, input int step_dir);
        m_mode   = 2;
        m_prev   = s;
        m_peak   = (s == MAXV);
        m_trough = (s == 0);
        m_dir    = (s == MAXV) ? 0 : (s == 0) ? 1 : step_dir;
    endtask

    always @(posedge clk) begin
        int s;
        bit bad;
        s   = int'(in_count);
        bad = 1'b0;
        if (rst) begin
            m_mode = 0; m_prev = 0; m_dir = 1; m_cnt = 0;
            m_peak = 0; m_trough = 0; m_err = 0;
        end else begin
            m_peak = 0; m_trough = 0; m_err = 0;
            if (in_valid) begin
                if (m_mode == 0) begin
                    m_prev = s; m_mode = 1;
                end else if (m_mode == 1) begin
                    if (m_prev != MAXV && s == m_prev + 1)   m_accept(s, 1);
                    else if (m_prev != 0 && s == m_prev - 1) m_accept(s, 0);
                    else                                     m_prev = s;
                end else begin
                    if (s == (m_dir ? m_prev + 1 : m_prev - 1)) m_accept(s, m_dir);
                    else begin
                        bad = 1'b1; m_err = 1; m_prev = s; m_mode = 1;
                    end
                end
            end
            if (err_clr)  m_cnt = bad ? 1 : 0;
            else if (bad) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One compare process: DUT vs model every cycle once out of initial reset.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("locked",    32'(locked),    32'(m_mode == 2));
            chk("dir",       32'(dir),       32'(m_dir));
            chk("peak",      32'(peak),      32'(m_peak));
            chk("trough",    32'(trough),    32'(m_trough));
            chk("err",       32'(err),       32'(m_err));
            chk("err_count", 32'(err_count), 32'(m_cnt));
            chk("excl", 32'((peak && trough) || (err && (peak || trough))), 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drive one cycle; on return the outputs reflect that cycle's edge.
    task automatic cyc(input bit v, input int c, input bit clr);
        in_valid = v;
        in_count = WIDTH'(c);
        err_clr  = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic smp(input int c);
        cyc(1'b1, c, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        int v, up;
        do_reset();
        cmp_en = 1'b1;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_dir",    32'(dir),    32'd1);
        chk("rst_cnt",    32'(err_count), 32'd0);

        // Full sweep with leading repeats.
        smp(0); smp(0); smp(0);
        chk("t1_prelock", 32'(locked), 32'd0);
        smp(1);
        chk("t1_lock", 32'(locked), 32'd1);
        for (int i = 2; i <= 6; i++) smp(i);
        smp(7);
        chk("t1_peak", 32'(peak), 32'd1);
        chk("t1_dir0", 32'(dir),  32'd0);
        for (int i = 6; i >= 1; i--) smp(i);
        smp(0);
        chk("t1_trough", 32'(trough), 32'd1);
        chk("t1_dir1",   32'(dir),    32'd1);
        smp(1);

        // Down-count error injection and re-lock.
        do_reset();
        smp(6); smp(5); smp(4);
        chk("t2_lockdn", 32'(locked), 32'd1);
        smp(6);
        chk("t2_err",    32'(err),       32'd1);
        chk("t2_cnt",    32'(err_count), 32'd1);
        chk("t2_unlock", 32'(locked),    32'd0);
        smp(5); smp(4);
        chk("t2_relock", 32'(locked),    32'd1);
        chk("t2_cnt2",   32'(err_count), 32'd1);

        // Wrap rejection.
        do_reset();
        smp(5); smp(6); smp(7); smp(0);
        chk("t3_err", 32'(err), 32'd1);
        smp(0);
        chk("t3_notrough", 32'(trough), 32'd0);
        chk("t3_hunt",     32'(locked), 32'd0);
        smp(1);
        chk("t3_relock", 32'(locked), 32'd1);

        // Alternating in_valid over a full sweep.
        do_reset();
        for (int i = 0; i < 2 * MAXV + 1; i++) begin
            v = (i <= MAXV) ? i : 2 * MAXV - i;
            smp(v);
            if (v == MAXV) chk("t4_peak", 32'(peak), 32'd1);
            cyc(1'b0, int'($urandom_range(0, MAXV)), 1'b0);
            chk("t4_gap_peak", 32'(peak | trough | err), 32'd0);
        end

        // Saturation and clear.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            smp(2); smp(3); smp(0);
        end
        chk("t5_sat", 32'(err_count), 32'd255);
        cyc(1'b0, 0, 1'b1);
        chk("t5_clr", 32'(err_count), 32'd0);
        smp(2); smp(3);
        cyc(1'b1, 0, 1'b1);
        chk("t5_clr_err", 32'(err_count), 32'd1);

        // Reset mid-sweep.
        do_reset();
        smp(1); smp(2); smp(5);
        smp(0); smp(1); smp(2); smp(3); smp(4);
        rst = 1'b1;
        smp(5);
        rst = 1'b0;
        chk("t6_locked", 32'(locked),    32'd0);
        chk("t6_dir",    32'(dir),       32'd1);
        chk("t6_cnt",    32'(err_count), 32'd0);
        smp(4); smp(3);
        chk("t6_lockdn", 32'(locked), 32'd1);
        chk("t6_dirdn",  32'(dir),    32'd0);

        // Randomised: mostly a clean bounce stream with glitches, gaps, clears, resets.
        do_reset();
        v = 0; up = 1;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 15) == 0) begin
                    cyc(1'b1, int'($urandom_range(0, MAXV)), $urandom_range(0, 31) == 0);
                end else begin
                    cyc(1'b1, v, $urandom_range(0, 31) == 0);
                    if (v == MAXV) up = 0;
                    else if (v == 0) up = 1;
                    v = up ? v + 1 : v - 1;
                end
            end else begin
                cyc(1'b0, int'($urandom_range(0, MAXV)), $urandom_range(0, 31) == 0);
            end
        end
        rst = 1'b0;
        cyc(1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tri_count_checker.md
# tri_count_checker

Receive-side monitor for the up/down bounce counter stream: 0→MAX→0, each endpoint held one sample. It samples the count bus, locks onto the sequence and predicts each next value. It flags peaks, troughs and sequence errors, and keeps a saturating error tally. It sits beside any bounce-counter instance in benches or on silicon as a self-check and event source.

## Interface
- WIDTH, 3, count bus width; MAX = 2^WIDTH−1; legal WIDTH ≥ 2
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_count is a sample this cycle
- in_count  input  WIDTH  observed counter value
- err_clr  input  1  clears err_count
- locked  output  1  checker is tracking the sequence
- dir  output  1  direction of the next expected step; 1 = up, 0 = down
- peak  output  1  one-cycle pulse: accepted sample == MAX
- trough  output  1  one-cycle pulse: accepted sample == 0
- err  output  1  one-cycle pulse: sample mismatched the prediction while locked
- err_count  output  8  saturating error tally

## Operation
- Internal state:
  - prev[WIDTH−1:0], last stored sample
  - FSM with states EMPTY, HUNT, LOCKED
- EMPTY: a valid sample is stored in prev; FSM → HUNT.
- HUNT, valid sample s:
  - s == prev+1 with prev != MAX: lock up; FSM → LOCKED.
  - s == prev−1 with prev != 0: lock down; FSM → LOCKED.
  - Otherwise: prev ← s, stay in HUNT. This covers repeats, jumps and wrap (MAX→0 or 0→MAX).
- LOCKED, valid sample s:
  - Expected value is prev+1 if dir = 1, prev−1 if dir = 0.
  - Match: sample is accepted; prev ← s.
  - Mismatch: err = 1; err_count increments; prev ← s; FSM → HUNT; locked ← 0; dir is unchanged.
- Accepted sample: either the locking sample in HUNT or a match in LOCKED.
  - dir after an accepted sample: s == MAX → 0; s == 0 → 1; otherwise the current step direction.
  - peak = (s == MAX); trough = (s == 0).
- in_valid = 0: no state change; peak, trough and err are 0.
- err_count arithmetic:
  - Saturates at 255.
  - err_clr alone sets it to 0.
  - err_clr together with a mismatch sets it to 1.
- Arithmetic is WIDTH bits with no wrap. The prev == MAX and prev == 0 cases are decided before ±1 is applied.

## Timing
- All outputs are registered. Effects of a sample at edge N appear after edge N, so they are visible in cycle N+1.
- Reset values: locked = 0, dir = 1, peak = 0, trough = 0, err = 0, err_count = 0, prev = 0, FSM = EMPTY.
- Reset mid-operation returns every output and the FSM to reset values on the next edge. err_count is cleared too.
- Lock latency: two valid samples from EMPTY. The second sample is checked and can already raise peak or trough.
- Error latency: err pulses the cycle after the bad sample. locked drops in the same cycle.
- Re-lock after an error: the next valid sample that steps ±1 from the bad sample re-locks.
- in_valid gaps: the sequence is checked over valid samples only, not clock cycles.
- peak and trough are never asserted together. err is never asserted together with either of them.

## Test plan
- Reset, then a 0,0,0 tail followed by 1..7,6..0,1 with WIDTH = 3:
  - locked rises after the 0→1 sample.
  - peak pulses once, after the 7.
  - trough pulses after the final 0.
  - dir is 0 after the 7 and 1 after the 0.
  - err stays 0.
- Locked down-counting at 5,4, then inject 6:
  - err pulses; err_count = 1; locked = 0.
  - Following 5,4 re-locks down with no further error.
- Wrap rejection: 6,7,0 while locked:
  - err pulses after the 0; FSM → HUNT.
  - A following 0,1 re-locks up; trough does not pulse on the relock 0.
- in_valid toggled every other cycle over a full 0→7→0 sweep:
  - Same pulses as continuous input, spaced by valid samples.
  - Outputs are unchanged during invalid cycles.
- Saturation and clear:
  - 300 forced mismatches → err_count = 255.
  - err_clr with no error → 0.
  - err_clr coinciding with a mismatch → 1.
- rst asserted mid-sweep at count 4:
  - All outputs take reset values on the next edge.
  - After release, a 4,3 pair locks down.
